// File: rtl/rtc_time_snap_master_if.sv
// Generic register bus between the snapshot master and the timestamp register block.
// data_in carries read data one cycle after rd_out.
interface rtc_time_snap_master_if;
    logic        wr_out;
    logic        rd_out;
    logic [7:0]  addr_out;
    logic [31:0] data_out;
    logic [31:0] data_in;

    modport master (
        output wr_out,
        output rd_out,
        output addr_out,
        output data_out,
        input  data_in
    );

    modport slave (
        input  wr_out,
        input  rd_out,
        input  addr_out,
        input  data_out,
        output data_in
    );
endinterface

// File: rtl/rtc_time_snap_master.sv
module rtc_time_snap_master #(
  parameter int unsigned POLL_LIMIT = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic [30:0] ctrl_base_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out,
  output logic [47:0] time_sec_out,
  output logic [37:0] time_ns_out,
  output logic        wr_out,
  output logic        rd_out,
  output logic [7:0]  addr_out,
  output logic [31:0] data_out,
  input  logic [31:0] data_in
);

  typedef enum logic [3:0] {
    IDLE, CLR, SET, WAIT1, WAIT2, POLL, CHK,
    R40, R44, R48, R4C, CAP, DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0] sec_hi_q;
  logic [31:0] sec_lo_q;
  logic [29:0] ns_hi_q;
  logic [47:0] time_sec_q;
  logic [37:0] time_ns_q;
  logic        timeout;

`ifdef RTC_SNAP_TIMEOUT_EN
  logic [CNT_W-1:0] poll_cnt_q;
  logic             err_q;

  assign timeout = !data_in[0] && (poll_cnt_q == CNT_W'(POLL_LIMIT));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = CLR;
      CLR:     state_d = SET;
      SET:     state_d = WAIT1;
      WAIT1:   state_d = WAIT2;
      WAIT2:   state_d = POLL;
      POLL:    state_d = CHK;
      CHK: begin
        if (data_in[0])   state_d = R40;
        else if (timeout) state_d = DONE;
        else              state_d = POLL;
      end
      R40:     state_d = R44;
      R44:     state_d = R48;
      R48:     state_d = R4C;
      R4C:     state_d = CAP;
      CAP:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_out   = 1'b0;
    rd_out   = 1'b0;
    addr_out = '0;
    data_out = '0;
    busy_out = (state_q != IDLE);
    done_out = 1'b0;
    err_out  = 1'b0;
    case (state_q)
      CLR: begin
        wr_out   = 1'b1;
        data_out = {ctrl_base_in, 1'b0};
      end
      SET: begin
        wr_out   = 1'b1;
        data_out = {ctrl_base_in, 1'b1};
      end
      POLL: rd_out = 1'b1;
      R40: begin
        rd_out   = 1'b1;
        addr_out = 8'h40;
      end
      R44: begin
        rd_out   = 1'b1;
        addr_out = 8'h44;
      end
      R48: begin
        rd_out   = 1'b1;
        addr_out = 8'h48;
      end
      R4C: begin
        rd_out   = 1'b1;
        addr_out = 8'h4C;
      end
      DONE: begin
        done_out = 1'b1;
`ifdef RTC_SNAP_TIMEOUT_EN
        err_out  = err_q;
`endif
      end
      default: ;
    endcase
  end

  // Read data lags its strobe by one cycle, so each word is staged in the following state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_hi_q   <= '0;
      sec_lo_q   <= '0;
      ns_hi_q    <= '0;
      time_sec_q <= '0;
      time_ns_q  <= '0;
    end else begin
      case (state_q)
        R44: sec_hi_q <= data_in[15:0];
        R48: sec_lo_q <= data_in;
        R4C: ns_hi_q  <= data_in[29:0];
        CAP: begin
          time_sec_q <= {sec_hi_q, sec_lo_q};
          time_ns_q  <= {ns_hi_q, data_in[7:0]};
        end
        default: ;
      endcase
    end
  end

`ifdef RTC_SNAP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        POLL: poll_cnt_q <= poll_cnt_q + 1'b1;
        CHK:  if (timeout) err_q <= 1'b1;
        DONE: begin
          poll_cnt_q <= '0;
          err_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`endif

  assign time_sec_out = time_sec_q;
  assign time_ns_out  = time_ns_q;

endmodule

// File: tb/tb_rtc_time_snap_master.sv
module tb_rtc_time_snap_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [30:0] base = '0;
  logic        busy, done, err;
  logic [47:0] tsec;
  logic [37:0] tns;

  int checks = 0;
  int errors = 0;
  int rd00_n = 0, rd4x_n = 0, done_n = 0, poll_n = 0, ok_after = 0;
  int d0, r0, r4;

  logic [31:0] ctrl_m = '0;
  logic [31:0] w40, w44, w48, w4c;
  logic [47:0] exp_sec, prev_sec;
  logic [37:0] exp_ns, prev_ns;

  rtc_time_snap_master_if bus();

  rtc_time_snap_master #(.POLL_LIMIT(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start),
    .ctrl_base_in (base),
    .busy_out     (busy),
    .done_out     (done),
    .err_out      (err),
    .time_sec_out (tsec),
    .time_ns_out  (tns),
    .wr_out       (bus.wr_out),
    .rd_out       (bus.rd_out),
    .addr_out     (bus.addr_out),
    .data_out     (bus.data_out),
    .data_in      (bus.data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic ok;
    ok = (ok_after != 0) && (poll_n + 1 >= ok_after);
    if (bus.rd_out) begin
      case (bus.addr_out)
        8'h00: begin
          bus.data_in <= {ctrl_m[31:1], ok};
          poll_n      <= poll_n + 1;
          rd00_n      <= rd00_n + 1;
        end
        8'h40: begin bus.data_in <= w40; rd4x_n <= rd4x_n + 1; end
        8'h44: begin bus.data_in <= w44; rd4x_n <= rd4x_n + 1; end
        8'h48: begin bus.data_in <= w48; rd4x_n <= rd4x_n + 1; end
        8'h4C: begin bus.data_in <= w4c; rd4x_n <= rd4x_n + 1; end
        default: bus.data_in <= 32'hBAD0_BAD0;
      endcase
    end else begin
      bus.data_in <= 32'hDEAD_BEEF;
    end
    if (bus.wr_out && bus.addr_out == 8'h00) begin
      ctrl_m <= bus.data_out;
      if (bus.data_out[0] && !ctrl_m[0]) poll_n <= 0;
    end
  end

  always @(negedge clk) begin
    checks++;
    assert (!(bus.wr_out && bus.rd_out)) else begin
      errors++;
      $error("FAIL strobe_excl wr=%0b rd=%0b required not both", bus.wr_out, bus.rd_out);
    end
    if (!bus.wr_out && !bus.rd_out) begin
      checks++;
      assert ({bus.addr_out, bus.data_out} === 40'h0) else begin
        errors++;
        $error("FAIL idle_bus addr=%h data=%h required 0", bus.addr_out, bus.data_out);
      end
    end
    if (done) done_n++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [44:0] observe();
    return {busy, done, err, bus.wr_out, bus.rd_out, bus.addr_out, bus.data_out};
  endfunction

  function automatic logic [44:0] expect_at(int c, int k, logic [30:0] b);
    int dc;
    logic [44:0] v;
    dc = 10 + 2 * k;
    v  = '0;
    if (c >= 1 && c <= dc) v[44] = 1'b1;
    if (c == 1) begin
      v[41] = 1'b1;
      v[31:0] = {b, 1'b0};
    end
    if (c == 2) begin
      v[41] = 1'b1;
      v[31:0] = {b, 1'b1};
    end
    if (c >= 5 && c <= 3 + 2 * k && ((c - 5) % 2 == 0)) v[40] = 1'b1;
    if (c >= 5 + 2 * k && c <= 8 + 2 * k) begin
      v[40] = 1'b1;
      v[39:32] = 8'h40 + 8'(4 * (c - 5 - 2 * k));
    end
    if (c == dc) v[43] = 1'b1;
    return v;
  endfunction

  task automatic run_seq(input int k, input int extra, input int last);
    @(negedge clk);
    start = 1'b1;
    chk($sformatf("k%0d_c0", k), observe(), '0);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = (c == extra);
      chk($sformatf("k%0d_c%0d", k, c), observe(), expect_at(c, k, base));
      if (c == 9 + 2 * k) begin
        chk("sec_hold", tsec, prev_sec);
        chk("ns_hold", tns, prev_ns);
      end
      if (c == 10 + 2 * k) begin
        chk("sec_new", tsec, exp_sec);
        chk("ns_new", tns, exp_ns);
      end
    end
    start = 1'b0;
    prev_sec = exp_sec;
    prev_ns  = exp_ns;
  endtask

  initial begin
    prev_sec = '0;
    prev_ns  = '0;
    base = 31'h2AAA_5555;
    w40 = 32'h0000_ABCD; w44 = 32'h1234_5678; w48 = 32'h3FFF_FFFF; w4c = 32'h0000_00A5;

    repeat (3) @(negedge clk);
    chk("reset_outs", observe(), '0);
    chk("reset_sec", tsec, '0);
    chk("reset_ns", tns, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    ok_after = 3;
    exp_sec = 48'hABCD_1234_5678;
    exp_ns  = 38'h3F_FFFF_FFA5;
    d0 = done_n;
    run_seq(3, -1, 18);
    chk("done_cnt_1", 64'(done_n - d0), 64'd1);

    base = 31'h0123_4567;
    w40 = 32'hFFFF_1111; w44 = 32'h2222_3333; w48 = 32'hC444_4444; w4c = 32'hFFFF_FF5A;
    ok_after = 1;
    exp_sec = 48'h1111_2222_3333;
    exp_ns  = 38'h04_4444_445A;
    d0 = done_n;
    run_seq(1, 4, 12);
    w40 = 32'h0000_0001; w44 = 32'h0000_0002; w48 = 32'h0000_0003; w4c = 32'h0000_0004;
    ok_after = 2;
    exp_sec = 48'h0001_0000_0002;
    exp_ns  = 38'h304;
    run_seq(2, -1, 14);
    repeat (3) @(negedge clk);
    chk("done_cnt_2", 64'(done_n - d0), 64'd2);

    ok_after = 1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("rst_seq_c%0d", c), observe(), expect_at(c, 1, base));
    end
    rst = 1'b0;
    #1;
    chk("midrst_outs", observe(), '0);
    chk("midrst_sec", tsec, '0);
    chk("midrst_ns", tns, '0);
    @(negedge clk);
    rst = 1'b1;
    prev_sec = '0;
    prev_ns  = '0;
    w40 = 32'h0000_5A5A; w44 = 32'hCAFE_F00D; w48 = 32'h0000_0100; w4c = 32'h0000_0033;
    exp_sec = 48'h5A5A_CAFE_F00D;
    exp_ns  = 38'h1_0033;
    ok_after = 2;
    run_seq(2, -1, 14);

`ifdef RTC_SNAP_TIMEOUT_EN
    ok_after = 0;
    r0 = rd00_n; r4 = rd4x_n; d0 = done_n;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      logic [44:0] e;
      @(negedge clk);
      start = 1'b0;
      if (c <= 12)      e = expect_at(c, 5, base);
      else if (c == 13) e = {3'b111, 42'h0};
      else              e = '0;
      chk($sformatf("tmo_c%0d", c), observe(), e);
    end
    repeat (2) @(negedge clk);
    chk("tmo_polls", 64'(rd00_n - r0), 64'd4);
    chk("tmo_burst", 64'(rd4x_n - r4), 64'd0);
    chk("tmo_done", 64'(done_n - d0), 64'd1);
    chk("tmo_sec", tsec, prev_sec);
    chk("tmo_ns", tns, prev_ns);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
